// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at bit centres, with a one-byte holding
// register handed to the consumer over a valid/ready handshake.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

    generate
        if (DIV < 4) begin : gDivCheck
            $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic          sync1_q;
    logic          rs_q;
    logic          rsPrev_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frameErr_q;
    logic          overrun_q;
    logic          busy_q;

    // Edge detection needs a previous 1, so a break after a bad stop bit
    // cannot restart reception until the line has been seen high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            sync1_q    <= 1'b1;
            rs_q       <= 1'b1;
            rsPrev_q   <= 1'b1;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= rx;
            rs_q       <= sync1_q;
            rsPrev_q   <= rs_q;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rsPrev_q && !rs_q) begin
                        cnt_q   <= '0;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        if (!rs_q) begin
                            cnt_q   <= '0;
                            idx_q   <= 3'd0;
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        shift_q[idx_q] <= rs_q;
                        idx_q          <= idx_q + 3'd1;
                        cnt_q          <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        // A handshake in this same cycle frees the register for the new byte.
                        if (!rs_q) begin
                            frameErr_q <= 1'b1;
                        end else if (!valid_q || ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
